qbert_jump_ctrl: RTL and testbench
==================================

# qbert_jump_ctrl

- Sequences Qbert's moves on the 6-cube pyramid (ranks 1..3, 3/2/1 cubes).
- Accepts jump requests from the NIOS/Avalon side, computes the target cube from the live map parameters, and animates the sprite box over frame ticks.
- Tracks visited top faces, handles falls off the pyramid, lives and level completion.
- Drives `QBERT_POSITION_*`, `qbert_jump` and the visited mask consumed by the map renderer.

## Interface

Parameters:
- `QBERT_W`, 20: sprite width, px.
- `QBERT_H`, 20: sprite height, px.
- `JUMP_LOG2`, 3: jump lasts 2^JUMP_LOG2 frames.
- `FALL_FRAMES`, 16: frames spent falling before respawn.
- `FALL_STEP`, 8: px per frame subtracted from X while falling.
- `LIVES_INIT`, 3: lives after reset / `level_reset`.

Ports:
- `CLK_33` in 1: only clock. Reset is synchronous, active-high.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per displayed frame.
- `level_reset` in 1: synchronous restart of level state.
- `jump_req` in 1: request is held high until acked.
- `jump_dir` in 2: 0=DOWN_A, 1=DOWN_B, 2=UP_A, 3=UP_B.
- `jump_ack` out 1: one-cycle pulse when the request is accepted.
- `XLENGTH`, `XDIAG_DEMI`, `RANK1_X_OFFSET` in 11: map geometry.
- `YDIAG_DEMI`, `RANK1_Y_OFFSET` in 10: map geometry.
- `QBERT_POSITION_X0`, `QBERT_POSITION_X1` out 11: sprite box X.
- `QBERT_POSITION_Y0`, `QBERT_POSITION_Y1` out 10: sprite box Y.
- `qbert_jump` out 1: high in JUMP and FALL.
- `visited` out 6: bit order {R1n1,R1n2,R1n3,R2n1,R2n2,R3n1} = bits 5..0.
- `lives` out 2: lives remaining.
- `level_done` out 1: level completed.
- `game_over` out 1: no lives left.

## Operation

Cube (r,n) is valid for 1≤r≤3 and 1≤n≤4−r. Cube anchor:
- cx = RANK1_X_OFFSET − (r−1)·(XLENGTH+XDIAG_DEMI+1)
- cy = RANK1_Y_OFFSET + (r−1)·YDIAG_DEMI + (n−1)·(2·YDIAG_DEMI+1)

Sprite box:
- X0 = cx+XLENGTH+1, X1 = X0+QBERT_W−1
- Y0 = cy+YDIAG_DEMI−QBERT_H/2, Y1 = Y0+QBERT_H−1

Moves from (r,n):
- DOWN_A → (r−1,n)
- DOWN_B → (r−1,n+1)
- UP_A → (r+1,n−1)
- UP_B → (r+1,n)

Arithmetic:
- Internal arithmetic is 12-bit signed.
- Output coordinates are truncated to port width.

Reset and `level_reset` set:
- cube = (3,1), `visited` = 6'b000001
- `lives` = LIVES_INIT, `level_done` = 0, `game_over` = 0, `jump_ack` = 0, `qbert_jump` = 0
- Position = box of (3,1); state = IDLE

FSM:
- IDLE: if `jump_req` && !`level_done` && !`game_over`, pulse `jump_ack` and go to CALC. Otherwise hold.
- CALC (1 cycle): compute target.
  - Valid target: latch src/dst boxes and delta = dst−src, frame count k=0, go to JUMP.
  - Invalid target: go to FALL.
- JUMP: on each `frame_tick`, k++ and position += delta>>>JUMP_LOG2. When k reaches 2^JUMP_LOG2:
  - Snap position exactly to dst.
  - Set the dst bit in `visited`.
  - Return to IDLE.
- FALL: on each `frame_tick`, X0/X1 −= FALL_STEP, saturating at 0. After FALL_FRAMES ticks, `lives`−1.
  - Lives now 0: `game_over`=1, go to OVER; position frozen.
  - Otherwise respawn at (3,1) box and go to IDLE. `visited` is kept.
- OVER: only reset or `level_reset` exits.

Other rules:
- `level_done` = 1 the cycle after `visited` becomes 6'b111111. It is sticky.
- Map parameters are sampled only in CALC and at respawn. Changes mid-jump take effect on the next move.

## Timing

- `jump_ack` is asserted 1 cycle after `jump_req` is seen high in IDLE.
- Position updates 1 cycle after `frame_tick`.
- `qbert_jump` rises with the CALC→JUMP or CALC→FALL transition.
- `frame_tick` in IDLE or CALC is ignored.
- `jump_req` outside IDLE is not acked; the requester keeps it high.
- `level_reset` has priority over `frame_tick` and `jump_req` in the same cycle.
- `reset` mid-jump returns to the reset state on the next edge.
- A jump that completes the mask sets `level_done` 1 cycle after landing. No further acks follow.

## Configuration

- `QBERT_FALL_EN` defined: invalid targets enter FALL as above.
- `QBERT_FALL_EN` undefined: invalid targets are acked then discarded. CALC returns to IDLE, position and `lives` are unchanged, and `game_over` is tied 0.

## Structure

- `qbert_pkg` holds:
  - state enum {IDLE, CALC, JUMP, FALL, OVER}
  - dir enum
  - cube index type (r,n)
  - constant mapping (r,n) → `visited` bit
- Sub-module `qbert_cube_coord`: combinational (r,n) + map params → X0/X1/Y0/Y1. Instantiated twice (src, dst).

## Test plan

All tests use XLENGTH=55, XDIAG_DEMI=30, YDIAG_DEMI=50, RANK1_X_OFFSET=600, RANK1_Y_OFFSET=90.

1. Reset → X0=484, X1=503, Y0=230, Y1=249; visited=000001, lives=3.
2. Jump DOWN_A, 8 ticks → ack after 1 cycle, qbert_jump high for 8 frames, final X0=570, Y0=180, visited=000101.
3. From (3,1), UP_A (`QBERT_FALL_EN` on) → 16 ticks, X0 decreasing 8/frame, then lives=2 and box back to 484/230. With the macro off → ack only, position unchanged.
4. Visit all six cubes → visited=111111, level_done=1 next cycle, subsequent jump_req never acked.
5. Three falls → lives=0, game_over=1, state OVER. Then level_reset → reset values restored.
6. jump_req held high during JUMP → no ack until JUMP lands. reset asserted mid-jump → reset box on next edge.

Source files
------------

// File: rtl/qbert_pkg.sv
// Shared types for the Qbert jump controller: FSM states, jump
// directions, cube index, sprite box and the cube -> visited-bit map.
package qbert_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        JUMP,
        FALL,
        OVER
    } state_e;

    typedef enum logic [1:0] {
        DOWN_A = 2'd0,
        DOWN_B = 2'd1,
        UP_A   = 2'd2,
        UP_B   = 2'd3
    } dir_e;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] n;
    } cube_t;

    typedef struct packed {
        logic signed [11:0] x0;
        logic signed [11:0] x1;
        logic signed [11:0] y0;
        logic signed [11:0] y1;
    } box_t;

    localparam cube_t      HOME     = '{r: 2'd3, n: 2'd1};
    localparam logic [5:0] VIS_INIT = 6'b000001;
    localparam logic [5:0] VIS_ALL  = 6'b111111;

    // bit order {R1n1,R1n2,R1n3,R2n1,R2n2,R3n1}
    function automatic logic [5:0] vis_bit(input cube_t c);
        case ({c.r, c.n})
            4'b01_01: return 6'b100000;
            4'b01_10: return 6'b010000;
            4'b01_11: return 6'b001000;
            4'b10_01: return 6'b000100;
            4'b10_10: return 6'b000010;
            4'b11_01: return 6'b000001;
            default:  return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/qbert_jump_ctrl_if.sv
// Jump request handshake: requester holds jump_req until jump_ack pulses.
interface qbert_jump_ctrl_if;

    logic       jump_req;
    logic [1:0] jump_dir;
    logic       jump_ack;

    modport master (
        output jump_req,
        output jump_dir,
        input  jump_ack
    );

    modport slave (
        input  jump_req,
        input  jump_dir,
        output jump_ack
    );

endinterface

// File: rtl/qbert_cube_coord.sv
// Combinational cube (r,n) + live map geometry -> Qbert sprite box.
module qbert_cube_coord
    import qbert_pkg::*;
#(
    parameter int QBERT_W = 20,
    parameter int QBERT_H = 20
) (
    input  cube_t       cube,
    input  logic [10:0] xlength,
    input  logic [10:0] xdiag_demi,
    input  logic [10:0] rank1_x_offset,
    input  logic [9:0]  ydiag_demi,
    input  logic [9:0]  rank1_y_offset,
    output box_t        box
);

    localparam logic signed [11:0] W_M1   = 12'(QBERT_W - 1);
    localparam logic signed [11:0] H_M1   = 12'(QBERT_H - 1);
    localparam logic signed [11:0] H_HALF = 12'(QBERT_H / 2);

    logic signed [11:0] xl, xd, xo, yd, yo;
    logic signed [11:0] rm, nm, cx, cy;

    always_comb begin
        xl = $signed({1'b0, xlength});
        xd = $signed({1'b0, xdiag_demi});
        xo = $signed({1'b0, rank1_x_offset});
        yd = $signed({2'b00, ydiag_demi});
        yo = $signed({2'b00, rank1_y_offset});
        rm = $signed({10'd0, cube.r - 2'd1});
        nm = $signed({10'd0, cube.n - 2'd1});
        cx = xo - rm * (xl + xd + 12'sd1);
        cy = yo + rm * yd + nm * (yd + yd + 12'sd1);
        box.x0 = cx + xl + 12'sd1;
        box.x1 = box.x0 + W_M1;
        box.y0 = cy + yd - H_HALF;
        box.y1 = box.y0 + H_M1;
    end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Qbert move sequencer: jump handshake, sprite animation, visited mask.
// Define QBERT_FALL_EN to let invalid targets fall and cost a life.
module qbert_jump_ctrl
    import qbert_pkg::*;
#(
    parameter int QBERT_W     = 20,
    parameter int QBERT_H     = 20,
    parameter int JUMP_LOG2   = 3,
    parameter int FALL_FRAMES = 16,
    parameter int FALL_STEP   = 8,
    parameter int LIVES_INIT  = 3
) (
    input  logic                CLK_33,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                level_reset,
    qbert_jump_ctrl_if.slave    jif,
    input  logic [10:0]         XLENGTH,
    input  logic [10:0]         XDIAG_DEMI,
    input  logic [10:0]         RANK1_X_OFFSET,
    input  logic [9:0]          YDIAG_DEMI,
    input  logic [9:0]          RANK1_Y_OFFSET,
    output logic [10:0]         QBERT_POSITION_X0,
    output logic [10:0]         QBERT_POSITION_X1,
    output logic [9:0]          QBERT_POSITION_Y0,
    output logic [9:0]          QBERT_POSITION_Y1,
    output logic                qbert_jump,
    output logic [5:0]          visited,
    output logic [1:0]          lives,
    output logic                level_done,
    output logic                game_over
);

    localparam int KW = JUMP_LOG2 + 1;
    localparam int FW = $clog2(FALL_FRAMES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 ** JUMP_LOG2 - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FALL_FRAMES - 1);
    localparam logic signed [11:0] STEP = 12'(FALL_STEP);

    typedef struct packed {
        state_e             state;
        cube_t              cube;
        dir_e               dir;
        logic [KW-1:0]      k;
        logic [FW-1:0]      fcnt;
        box_t               pos;
        box_t               dst;
        logic signed [11:0] ddx;
        logic signed [11:0] ddy;
        logic [5:0]         visited;
        logic [1:0]         lives;
        logic               done;
        logic               over;
        logic               ack;
        logic               jump;
    } regs_t;

    regs_t st_q, st_d, init_s;
    cube_t src_cube, tgt;
    box_t  src_box, dst_box;
    logic  tgt_ok;
    logic signed [3:0]  tr, tn;
    logic signed [11:0] sx, sy;

    function automatic logic signed [11:0] fall_x(input logic signed [11:0] x);
        return (x >= STEP) ? x - STEP : 12'sd0;
    endfunction

    // Respawn and reset boxes always come from the home cube.
    assign src_cube = (reset || level_reset || st_q.state == FALL) ?
                      HOME : st_q.cube;

    qbert_cube_coord #(.QBERT_W(QBERT_W), .QBERT_H(QBERT_H)) u_src (
        .cube           (src_cube),
        .xlength        (XLENGTH),
        .xdiag_demi     (XDIAG_DEMI),
        .rank1_x_offset (RANK1_X_OFFSET),
        .ydiag_demi     (YDIAG_DEMI),
        .rank1_y_offset (RANK1_Y_OFFSET),
        .box            (src_box)
    );

    qbert_cube_coord #(.QBERT_W(QBERT_W), .QBERT_H(QBERT_H)) u_dst (
        .cube           (tgt),
        .xlength        (XLENGTH),
        .xdiag_demi     (XDIAG_DEMI),
        .rank1_x_offset (RANK1_X_OFFSET),
        .ydiag_demi     (YDIAG_DEMI),
        .rank1_y_offset (RANK1_Y_OFFSET),
        .box            (dst_box)
    );

    always_comb begin
        tr = $signed({2'b00, st_q.cube.r});
        tn = $signed({2'b00, st_q.cube.n});
        unique case (st_q.dir)
            DOWN_A: tr = tr - 4'sd1;
            DOWN_B: begin
                tr = tr - 4'sd1;
                tn = tn + 4'sd1;
            end
            UP_A: begin
                tr = tr + 4'sd1;
                tn = tn - 4'sd1;
            end
            UP_B: tr = tr + 4'sd1;
        endcase
        tgt_ok = (tr >= 4'sd1) && (tr <= 4'sd3) &&
                 (tn >= 4'sd1) && (tn <= 4'sd4 - tr);
        tgt = '{r: tr[1:0], n: tn[1:0]};
    end

    always_comb begin
        init_s         = '0;
        init_s.state   = IDLE;
        init_s.cube    = HOME;
        init_s.dir     = DOWN_A;
        init_s.pos     = src_box;
        init_s.dst     = src_box;
        init_s.visited = VIS_INIT;
        init_s.lives   = 2'(LIVES_INIT);
    end

    always_comb begin
        sx = $signed(st_q.ddx) >>> JUMP_LOG2;
        sy = $signed(st_q.ddy) >>> JUMP_LOG2;
        st_d     = st_q;
        st_d.ack = 1'b0;
        if (level_reset) begin
            st_d = init_s;
        end else begin
            unique case (st_q.state)
                IDLE: begin
                    if (jif.jump_req && !st_q.done && !st_q.over &&
                        st_q.visited != VIS_ALL) begin
                        st_d.ack   = 1'b1;
                        st_d.dir   = dir_e'(jif.jump_dir);
                        st_d.state = CALC;
                    end
                end
                CALC: begin
                    if (tgt_ok) begin
                        st_d.pos   = src_box;
                        st_d.dst   = dst_box;
                        st_d.ddx   = dst_box.x0 - src_box.x0;
                        st_d.ddy   = dst_box.y0 - src_box.y0;
                        st_d.k     = '0;
                        st_d.cube  = tgt;
                        st_d.state = JUMP;
                        st_d.jump  = 1'b1;
                    end else begin
`ifdef QBERT_FALL_EN
                        st_d.pos   = src_box;
                        st_d.fcnt  = '0;
                        st_d.state = FALL;
                        st_d.jump  = 1'b1;
`else
                        st_d.state = IDLE;
`endif
                    end
                end
                JUMP: begin
                    if (frame_tick) begin
                        if (st_q.k == K_LAST) begin
                            // land exactly; the shifted steps drift
                            st_d.pos     = st_q.dst;
                            st_d.visited = st_q.visited | vis_bit(st_q.cube);
                            st_d.state   = IDLE;
                            st_d.jump    = 1'b0;
                        end else begin
                            st_d.k      = st_q.k + KW'(1);
                            st_d.pos.x0 = st_q.pos.x0 + sx;
                            st_d.pos.x1 = st_q.pos.x1 + sx;
                            st_d.pos.y0 = st_q.pos.y0 + sy;
                            st_d.pos.y1 = st_q.pos.y1 + sy;
                        end
                    end
                end
                FALL: begin
                    if (frame_tick) begin
                        st_d.pos.x0 = fall_x(st_q.pos.x0);
                        st_d.pos.x1 = fall_x(st_q.pos.x1);
                        st_d.fcnt   = st_q.fcnt + FW'(1);
                        if (st_q.fcnt == F_LAST) begin
                            st_d.lives = st_q.lives - 2'd1;
                            st_d.jump  = 1'b0;
                            if (st_q.lives == 2'd1) begin
                                st_d.over  = 1'b1;
                                st_d.state = OVER;
                            end else begin
                                st_d.pos   = src_box;
                                st_d.cube  = HOME;
                                st_d.state = IDLE;
                            end
                        end
                    end
                end
                default: ;
            endcase
            st_d.done = st_q.done | (st_q.visited == VIS_ALL);
        end
    end

    always_ff @(posedge CLK_33) begin
        if (reset) st_q <= init_s;
        else       st_q <= st_d;
    end

    assign jif.jump_ack       = st_q.ack;
    assign QBERT_POSITION_X0  = st_q.pos.x0[10:0];
    assign QBERT_POSITION_X1  = st_q.pos.x1[10:0];
    assign QBERT_POSITION_Y0  = st_q.pos.y0[9:0];
    assign QBERT_POSITION_Y1  = st_q.pos.y1[9:0];
    assign qbert_jump         = st_q.jump;
    assign visited            = st_q.visited;
    assign lives              = st_q.lives;
    assign level_done         = st_q.done;
    assign game_over          = st_q.over;

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Directed bench for qbert_jump_ctrl with hand-computed sprite boxes
// for XLENGTH=55 XDIAG_DEMI=30 YDIAG_DEMI=50 X_OFF=600 Y_OFF=90.
module tb_qbert_jump_ctrl;

    logic        clk = 1'b0;
    logic        reset, level_reset, frame_tick;
    logic [10:0] xlength, xdiag, xoff;
    logic [9:0]  ydiag, yoff;
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    logic        qj, done, over;
    logic [5:0]  vis;
    logic [1:0]  lives;

    int n_cmp = 0;
    int n_bad = 0;
    int acks  = 0;
    int a0;

    qbert_jump_ctrl_if jif ();

    qbert_jump_ctrl dut (
        .CLK_33            (clk),
        .reset             (reset),
        .frame_tick        (frame_tick),
        .level_reset       (level_reset),
        .jif               (jif),
        .XLENGTH           (xlength),
        .XDIAG_DEMI        (xdiag),
        .RANK1_X_OFFSET    (xoff),
        .YDIAG_DEMI        (ydiag),
        .RANK1_Y_OFFSET    (yoff),
        .QBERT_POSITION_X0 (x0),
        .QBERT_POSITION_X1 (x1),
        .QBERT_POSITION_Y0 (y0),
        .QBERT_POSITION_Y1 (y1),
        .qbert_jump        (qj),
        .visited           (vis),
        .lives             (lives),
        .level_done        (done),
        .game_over         (over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (jif.jump_ack) acks++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic req_jump(input logic [1:0] d);
        jif.jump_req = 1'b1;
        jif.jump_dir = d;
        cyc();
        jif.jump_req = 1'b0;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] tour [6];
        tour = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1};
        reset = 1'b1; level_reset = 1'b0; frame_tick = 1'b0;
        jif.jump_req = 1'b0; jif.jump_dir = 2'd0;
        xlength = 11'd55; xdiag = 11'd30; xoff = 11'd600;
        ydiag = 10'd50; yoff = 10'd90;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        check("rst_x0", x0, 484);
        check("rst_x1", x1, 503);
        check("rst_y0", y0, 230);
        check("rst_y1", y1, 249);
        check("rst_vis", vis, 1);
        check("rst_lives", lives, 3);
        check("rst_done", done, 0);
        check("rst_over", over, 0);
        check("rst_qj", qj, 0);
        check("rst_ack", jif.jump_ack, 0);

        a0 = acks;
        req_jump(2'd2);
        check("inv_ack", acks - a0, 1);
`ifdef QBERT_FALL_EN
        check("fall_qj", qj, 1);
        ticks(1);
        check("fall_x0_1", x0, 476);
        check("fall_x1_1", x1, 495);
        ticks(1);
        check("fall_x0_2", x0, 468);
        ticks(13);
        check("fall_x0_15", x0, 364);
        check("fall_lives_15", lives, 3);
        ticks(1);
        check("fall_lives", lives, 2);
        check("fall_rsp_x0", x0, 484);
        check("fall_rsp_y0", y0, 230);
        check("fall_rsp_qj", qj, 0);
`else
        check("inv_qj", qj, 0);
        check("inv_x0", x0, 484);
        check("inv_lives", lives, 3);
        ticks(2);
        check("inv_idle_x0", x0, 484);
`endif

        a0 = acks;
        jif.jump_req = 1'b1;
        jif.jump_dir = 2'd0;
        cyc();
        check("ja_ack", jif.jump_ack, 1);
        cyc();
        check("ja_qj", qj, 1);
        ticks(1);
        check("ja_x0_1", x0, 494);
        check("ja_x1_1", x1, 513);
        check("ja_y0_1", y0, 223);
        ticks(7);
        check("ja_noack", acks - a0, 1);
        check("ja_x0", x0, 570);
        check("ja_x1", x1, 589);
        check("ja_y0", y0, 180);
        check("ja_y1", y1, 199);
        check("ja_vis", vis, 5);
        check("ja_qj_end", qj, 0);
        cyc();
        check("ja_reack", jif.jump_ack, 1);
        jif.jump_req = 1'b0;
        cyc();
        ticks(3);
        check("j2_x0_3", x0, 600);
        check("j2_y0_3", y0, 159);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_x0", x0, 484);
        check("mid_rst_y0", y0, 230);
        check("mid_rst_vis", vis, 1);
        check("mid_rst_qj", qj, 0);
        check("mid_rst_lives", lives, 3);
        cyc();

        foreach (tour[i]) begin
            req_jump(tour[i]);
            ticks(8);
        end
        check("tour_vis", vis, 63);
        check("tour_done_early", done, 0);
        check("tour_x0", x0, 656);
        check("tour_y0", y0, 332);
        cyc();
        check("tour_done", done, 1);
        a0 = acks;
        jif.jump_req = 1'b1;
        repeat (10) cyc();
        jif.jump_req = 1'b0;
        check("done_noack", acks - a0, 0);
        check("done_sticky", done, 1);

        level_reset = 1'b1;
        cyc();
        level_reset = 1'b0;
        check("lr_vis", vis, 1);
        check("lr_done", done, 0);
        check("lr_x0", x0, 484);
        level_reset = 1'b1; frame_tick = 1'b1; jif.jump_req = 1'b1;
        cyc();
        level_reset = 1'b0; frame_tick = 1'b0; jif.jump_req = 1'b0;
        check("lr_prio_ack", jif.jump_ack, 0);
        cyc();
        check("lr_prio_ack2", jif.jump_ack, 0);
        check("lr_prio_qj", qj, 0);

`ifdef QBERT_FALL_EN
        for (int i = 0; i < 3; i++) begin
            req_jump(2'd2);
            ticks(16);
            check("falls_lives", lives, 32'(2 - i));
        end
        check("go_over", over, 1);
        check("go_qj", qj, 0);
        a0 = acks;
        req_jump(2'd0);
        check("go_noack", acks - a0, 0);
        level_reset = 1'b1;
        cyc();
        level_reset = 1'b0;
        check("go_lr_lives", lives, 3);
        check("go_lr_over", over, 0);
        check("go_lr_x0", x0, 484);
        check("go_lr_vis", vis, 1);
`else
        a0 = acks;
        for (int i = 0; i < 3; i++) req_jump(2'd3);
        check("inv3_acks", acks - a0, 3);
        check("inv3_lives", lives, 3);
        check("inv3_over", over, 0);
        check("inv3_x0", x0, 484);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
